seq_det_scheduler: RTL and testbench
====================================

SEQ_DET_SCHEDULER -- requirements
Module: seq_det_scheduler

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, bits per granted frame (range 4..255).
REQ-002 SHALL have parameter CNT_W, default 5, match-counter width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  in  2  per-channel request, level-held by the requester.
REQ-006 SHALL have port in  in  2  per-channel serial data bit; in[i] belongs to channel i.
REQ-007 SHALL have port pattern  in  4  target sequence, pattern[3] is the oldest bit; latched at grant.
REQ-008 SHALL have port overlap  in  1  1 = overlapping detection, 0 = non-overlapping; latched at grant.
REQ-009 SHALL have port gnt  out  2  one-hot grant; high for the whole frame.
REQ-010 SHALL have port out  out  1  Mealy match indication for the granted channel.
REQ-011 SHALL have port done  out  1  single-cycle end-of-frame pulse.
REQ-012 SHALL have port done_ch  out  1  channel index of the last completed frame.
REQ-013 SHALL have port match_cnt  out  CNT_W  matches in the current or last frame.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE SHALL go to RUN at the first edge E0 where req!=0; on that edge the block SHALL set gnt, latch pattern/overlap, clear the detector and clear match_cnt.
REQ-016 Arbitration SHALL be round-robin: with both req high, the channel not served last wins. After reset, channel 0 wins.
REQ-017 RUN SHALL last exactly FRAME_LEN cycles. The granted channel's in SHALL be sampled at edges E0+1 .. E0+FRAME_LEN. The bit counter SHALL run 0..FRAME_LEN-1.
REQ-018 At edge E0+FRAME_LEN the FSM SHALL enter DONE: gnt=0, done=1 for one cycle, and done_ch=served channel. It SHALL return to IDLE at the next edge.
REQ-019 A new grant SHALL NOT be issued in DONE, so frames are separated by at least one idle cycle.
REQ-020 A req deassert during RUN SHALL be ignored; the frame completes and bits continue to be sampled.
REQ-021 out SHALL be combinational and asserted only in RUN. It is high when {hist[2:0], current in bit} == latched pattern and hist_cnt >= 3.
REQ-022 The detector SHALL keep a 3-bit history shift register hist and a saturating valid count hist_cnt (0..3).
REQ-023 On a sampled match with overlap=0, the detector SHALL clear hist_cnt to 0, so the next match needs 4 fresh bits.
REQ-024 On a sampled match with overlap=1, the detector SHALL keep hist_cnt unchanged.
REQ-025 match_cnt SHALL increment on each sampled match and saturate at 2^CNT_W-1.
REQ-026 match_cnt SHALL hold its value through DONE and IDLE until the next grant.
REQ-027 done_ch SHALL hold its value until the next DONE.
REQ-028 pattern and overlap changes during RUN SHALL have no effect.

Reset
REQ-029 Asserting reset SHALL immediately force the state to IDLE and set gnt=0, out=0, done=0, done_ch=0, match_cnt=0, hist_cnt=0, and the round-robin pointer to favour channel 0.
REQ-030 Reset mid-frame SHALL abort the frame with no done pulse.
REQ-031 The first grant after reset release SHALL occur no earlier than the first rising edge at which reset is low.

Structure
REQ-032 The state encoding (IDLE/RUN/DONE) and the channel-count constant (2) SHALL live in a shared package seq_det_pkg.
REQ-033 The detector (hist, hist_cnt, pattern compare, overlap handling, clear input, enable input) SHALL be a sub-module named seq4_det_mealy, instantiated once and shared by both channels.

Verification
REQ-034 The bench SHALL cover the following directed scenarios, each with the stated required response:
- FRAME_LEN=16, pattern=1101, overlap=0, req[0]=1, ch0 bits 1,1,0,1,1,0,1,0,1 then zeros -> out high only on bit 3; match_cnt=1; done=1 at E0+16; done_ch=0.
- Same stream with overlap=1 -> out high on bits 3 and 6; match_cnt=2.
- req=2'b11 right after reset -> gnt=01 for 16 cycles, one-cycle done, one IDLE cycle, then gnt=10.
- CNT_W=2, pattern=0000, overlap=1, 16 zeros -> 13 raw matches; match_cnt saturates at 3.
- reset asserted at bit 7 of a frame -> gnt, out and match_cnt go to 0 without waiting for a clock edge; no done pulse; the next grant goes to channel 0.
- req[1] dropped after 2 bits -> frame still runs 16 cycles and done_ch=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-detecting frame scheduler.
package seq_det_pkg;

  // Number of requesting channels served by the scheduler.
  localparam int NUM_CH = 2;

  // Frame scheduler states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq4_det_mealy.sv
// 4-bit Mealy sequence detector.
// It keeps a 3-bit history and a saturating count of how many history bits are valid.
// A single instance is shared by both channels.
module seq4_det_mealy (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       din,
  input  logic [3:0] pattern,
  input  logic       overlap,
  output logic       match
);

  logic [2:0] hist;
  logic [1:0] hist_cnt;

  // Match needs three valid history bits plus the bit currently on din.
  assign match = (hist_cnt == 2'd3) && ({hist, din} == pattern);

  // History shift and valid count.
  // A non-overlapping match restarts the count, so the next match needs four fresh bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist     <= 3'd0;
      hist_cnt <= 2'd0;
    end else if (clear) begin
      hist     <= 3'd0;
      hist_cnt <= 2'd0;
    end else if (enable) begin
      hist <= {hist[1:0], din};
      if (match && !overlap) begin
        hist_cnt <= 2'd0;
      end else if (hist_cnt != 2'd3) begin
        hist_cnt <= hist_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Two-channel round-robin frame scheduler.
// During each frame, the granted channel's serial stream is run through a shared 4-bit sequence detector.
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] in,
  input  logic [3:0]        pattern,
  input  logic              overlap,
  output logic [NUM_CH-1:0] gnt,
  output logic              out,
  output logic              done,
  output logic              done_ch,
  output logic [CNT_W-1:0]  match_cnt
);

  state_t     state, state_next;
  logic [7:0] bit_cnt;
  logic       ch;
  logic       last_ch;
  logic       grant_ch;
  logic [3:0] pat_lat;
  logic       ovl_lat;
  logic       start;
  logic       last_bit;
  logic       det_match;

  assign start    = (state == IDLE) && (req != '0);
  assign last_bit = (bit_cnt == 8'(FRAME_LEN - 1));

  // Round-robin pick: on contention the channel not served last wins.
  always_comb begin
    grant_ch = req[1];
    if (req == 2'b11) begin
      grant_ch = ~last_ch;
    end
  end

  // Frame sequencing: one grant, FRAME_LEN sampled bits, then a one-cycle DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant-time latches, bit counter, match counter and completed-channel record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch        <= 1'b0;
      last_ch   <= 1'b1;
      pat_lat   <= 4'd0;
      ovl_lat   <= 1'b0;
      bit_cnt   <= 8'd0;
      done_ch   <= 1'b0;
      match_cnt <= '0;
    end else begin
      if (start) begin
        ch        <= grant_ch;
        last_ch   <= grant_ch;
        pat_lat   <= pattern;
        ovl_lat   <= overlap;
        bit_cnt   <= 8'd0;
        match_cnt <= '0;
      end
      if (state == RUN) begin
        bit_cnt <= bit_cnt + 8'd1;
        if (out && (match_cnt != {CNT_W{1'b1}})) begin
          match_cnt <= match_cnt + 1'b1;
        end
        if (last_bit) begin
          done_ch <= ch;
        end
      end
    end
  end

  seq4_det_mealy u_det (
    .clk     (clk),
    .reset   (reset),
    .clear   (start),
    .enable  (state == RUN),
    .din     (in[ch]),
    .pattern (pat_lat),
    .overlap (ovl_lat),
    .match   (det_match)
  );

  assign out  = (state == RUN) && det_match;
  assign done = (state == DONE);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_gnt
    assign gnt[gi] = (state == RUN) && (ch == 1'(gi));
  end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler.
// A second instance with CNT_W=2 shares the same stimulus to exercise match-counter saturation.
module tb_seq_det_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] din;
  logic [3:0] pattern;
  logic       overlap;

  logic [1:0] gnt, gnt2;
  logic       out, out2, done, done2, done_ch, done_ch2;
  logic [4:0] match_cnt;
  logic [1:0] match_cnt2;

  int vectors     = 0;
  int miscompares = 0;

  seq_det_scheduler #(.FRAME_LEN(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .req(req), .in(din), .pattern(pattern), .overlap(overlap),
    .gnt(gnt), .out(out), .done(done), .done_ch(done_ch), .match_cnt(match_cnt)
  );

  seq_det_scheduler #(.FRAME_LEN(16), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .req(req), .in(din), .pattern(pattern), .overlap(overlap),
    .gnt(gnt2), .out(out2), .done(done2), .done_ch(done_ch2), .match_cnt(match_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete frame: grant edge, 16 bits, DONE cycle, return to IDLE.
  task automatic run_frame(input logic [1:0] req_v, input logic [15:0] bits,
                           input logic [15:0] exp_out, input int c, input int drop_at,
                           input logic [4:0] exp_cnt, input logic [1:0] exp_cnt2,
                           input logic scramble);
    logic [1:0] g;
    g = (c == 0) ? 2'b01 : 2'b10;
    req = req_v;
    tick();
    if (scramble) begin
      pattern = 4'b0000;
      overlap = 1'b1;
    end
    chk("grant", 16'(gnt), 16'(g));
    chk("cnt_clear", 16'(match_cnt), 16'd0);
    for (int k = 0; k < 16; k++) begin
      if (k == drop_at) req = 2'b00;
      din[c]     = bits[k];
      din[1 - c] = ~bits[k];
      #4;
      chk($sformatf("out_b%0d", k), 16'(out), 16'(exp_out[k]));
      chk($sformatf("gnt_b%0d", k), 16'(gnt), 16'(g));
      tick();
    end
    chk("done", 16'(done), 16'd1);
    chk("gnt_done", 16'(gnt), 16'd0);
    chk("done_ch", 16'(done_ch), 16'(c));
    chk("match_cnt", 16'(match_cnt), 16'(exp_cnt));
    chk("match_cnt_sat", 16'(match_cnt2), 16'(exp_cnt2));
    tick();
    chk("done_low", 16'(done), 16'd0);
    chk("gnt_idle", 16'(gnt), 16'd0);
    chk("cnt_hold", 16'(match_cnt), 16'(exp_cnt));
    chk("done_ch_hold", 16'(done_ch), 16'(c));
  endtask

  initial begin
    reset   = 1'b1;
    req     = 2'b00;
    din     = 2'b00;
    pattern = 4'b1101;
    overlap = 1'b0;
    #2;
    chk("rst_gnt", 16'(gnt), 16'd0);
    chk("rst_out", 16'(out), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_done_ch", 16'(done_ch), 16'd0);
    chk("rst_cnt", 16'(match_cnt), 16'd0);
    tick();
    tick();
    reset = 1'b0;

    // Contention right after reset: ch0 first, then ch1 after one idle cycle; ch1 drops req after 2 bits.
    run_frame(2'b11, 16'h0000, 16'h0000, 0, 99, 5'd0, 2'd0, 1'b0);
    run_frame(2'b11, 16'h0000, 16'h0000, 1, 2, 5'd0, 2'd0, 1'b0);

    // Stream 1,1,0,1,1,0,1,0,1,0... non-overlapping; pattern/overlap changed mid-frame.
    pattern = 4'b1101; overlap = 1'b0;
    run_frame(2'b01, 16'h015B, 16'h0008, 0, 0, 5'd1, 2'd1, 1'b1);

    // Same stream, overlapping.
    pattern = 4'b1101; overlap = 1'b1;
    run_frame(2'b01, 16'h015B, 16'h0048, 0, 0, 5'd2, 2'd2, 1'b0);

    // All zeros against 0000 with overlap: 13 matches, 2-bit counter saturates at 3.
    pattern = 4'b0000; overlap = 1'b1;
    run_frame(2'b01, 16'h0000, 16'hFFF8, 0, 0, 5'd13, 2'd3, 1'b0);

    // Reset in the middle of a frame, while bit 7 is presented.
    pattern = 4'b0000; overlap = 1'b1;
    req = 2'b01;
    tick();
    din = 2'b10;
    repeat (7) tick();
    chk("pre_rst_cnt", 16'(match_cnt), 16'd4);
    chk("pre_rst_out", 16'(out), 16'd1);
    chk("pre_rst_gnt", 16'(gnt), 16'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_gnt", 16'(gnt), 16'd0);
    chk("abort_out", 16'(out), 16'd0);
    chk("abort_cnt", 16'(match_cnt), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    tick();
    chk("abort_done_edge", 16'(done), 16'd0);
    chk("abort_gnt_edge", 16'(gnt), 16'd0);
    reset = 1'b0;

    // After reset, contention goes to ch0 again.
    pattern = 4'b1101; overlap = 1'b0;
    run_frame(2'b11, 16'h0000, 16'h0000, 0, 0, 5'd0, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
